// File: rtl/xnor_row_seq.sv
// Frame sequencer for the 7-bit XNOR binary neuron: a 7x7 weight kernel, row-wise
// XNOR/popcount accumulation, and a thresholded result over a valid/ready port.

module xnor_lane (
    input  logic a,
    input  logic b,
    output logic m
);
    assign m = ~(a ^ b);
endmodule

module xnor_row_seq #(
    parameter int ROWS  = 7,
    parameter int WIDTH = 7,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_load,
    input  logic [2:0]       w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [ACC_W-1:0] thresh,
    input  logic             img_valid,
    output logic             img_ready,
    input  logic [WIDTH-1:0] img_row,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic             res_bit,
    output logic             busy
);
    localparam int PC_W = $clog2(WIDTH + 1);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                      state;
    logic [2:0]                  row_cnt;
    logic [ACC_W-1:0]            acc;
    logic [ACC_W-1:0]            thr_q;
    logic [ROWS-1:0][WIDTH-1:0]  weight;

    logic [WIDTH-1:0] cur_w;
    logic [WIDTH-1:0] match;
    logic [PC_W-1:0]  pc;
    logic [ACC_W-1:0] sum_next;
    logic             accept;

    assign cur_w = weight[row_cnt];

    xnor_lane u_lane [WIDTH-1:0] (
        .a (img_row),
        .b (cur_w),
        .m (match)
    );

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++)
            pc = pc + PC_W'(match[i]);
    end

    assign sum_next  = acc + ACC_W'(pc);
    // A weight write in IDLE blocks frame start so the two never share a cycle.
    assign img_ready = rst_n && (state != DONE) && !(state == IDLE && w_load);
    assign accept    = img_valid && img_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_cnt   <= '0;
            acc       <= '0;
            thr_q     <= '0;
            weight    <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_bit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_load && (w_addr <= LAST_ROW))
                        weight[w_addr] <= w_data;
                    if (accept) begin
                        thr_q   <= thresh;
                        acc     <= ACC_W'(pc);
                        row_cnt <= 3'd1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (row_cnt == LAST_ROW) begin
                            res_sum   <= sum_next;
                            res_bit   <= (sum_next >= thr_q);
                            res_valid <= 1'b1;
                            acc       <= '0;
                            row_cnt   <= '0;
                            state     <= DONE;
                        end else begin
                            acc     <= sum_next;
                            row_cnt <= row_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    // res_sum/res_bit stay at their last value after the handshake.
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xnor_row_seq.sv
// Directed bench for xnor_row_seq: a reference model pushes expected frame
// results to a scoreboard queue that is drained when the DUT presents a result.

module tb_xnor_row_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_load = 1'b0;
    logic [2:0] w_addr = '0;
    logic [6:0] w_data = '0;
    logic [5:0] thresh = '0;
    logic       img_valid = 1'b0;
    logic       img_ready;
    logic [6:0] img_row = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_sum;
    logic       res_bit;
    logic       busy;

    always #5 clk = ~clk;

    xnor_row_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_load    (w_load),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .thresh    (thresh),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .img_row   (img_row),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_bit   (res_bit),
        .busy      (busy)
    );

    typedef struct packed {
        logic [5:0] sum;
        logic       bt;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] wm[7];
    logic [6:0] frame_rows[7];
    int         errs = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popc7(input logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic write_w(input logic [2:0] a, input logic [6:0] d);
        w_load = 1'b1; w_addr = a; w_data = d;
        tick();
        w_load = 1'b0;
        if (a < 3'd7) wm[a] = d;
    endtask

    task automatic fill_w(input logic [6:0] d);
        for (int i = 0; i < 7; i++) write_w(3'(i), d);
    endtask

    task automatic send_row(input logic [6:0] r);
        int n = 0;
        img_row = r; img_valid = 1'b1;
        #1;
        while (!img_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("row_accept_timeout", 0, 1);
        tick();
        img_valid = 1'b0;
    endtask

    // mid: after the first row, zero thresh and attempt a weight write in ACCUM
    task automatic run_frame(input logic [5:0] thr, input bit gaps, input bit mid);
        int s = 0;
        for (int i = 0; i < 7; i++) s += popc7(~(frame_rows[i] ^ wm[i]));
        sb.push_back({6'(s), (s >= int'(thr))});
        thresh = thr;
        for (int i = 0; i < 7; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (mid && i == 1) thresh = 6'd0;
            if (mid && i == 3) begin
                w_load = 1'b1; w_addr = 3'd2; w_data = 7'h00;
                tick();
                w_load = 1'b0;
            end
            if (i == 6) chk("valid_before_last_row", 32'(res_valid), 0);
            send_row(frame_rows[i]);
        end
        chk("valid_after_7th", 32'(res_valid), 1);
        chk("ready_in_done", 32'(img_ready), 0);
        chk("busy_in_done", 32'(busy), 1);
    endtask

    task automatic collect();
        exp_t e;
        int   n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        if (n >= 50) chk("result_timeout", 0, 1);
        else if (sb.size() == 0) chk("scoreboard_empty", 0, 1);
        else begin
            e = sb.pop_front();
            chk("res_sum", 32'(res_sum), 32'(e.sum));
            chk("res_bit", 32'(res_bit), 32'(e.bt));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("idle_after_accept", 32'(busy), 0);
            chk("valid_drop", 32'(res_valid), 0);
            chk("sum_held", 32'(res_sum), 32'(e.sum));
        end
    endtask

    task automatic set_rows(input logic [6:0] r);
        for (int i = 0; i < 7; i++) frame_rows[i] = r;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) wm[i] = 7'h00;

        // reset state
        repeat (3) tick();
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_sum", 32'(res_sum), 0);
        chk("rst_res_bit", 32'(res_bit), 0);
        chk("rst_busy", 32'(busy), 0);
        img_valid = 1'b1; #1;
        chk("rst_img_ready", 32'(img_ready), 0);
        img_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_img_ready", 32'(img_ready), 1);

        // 1: all ones -> 49
        fill_w(7'h7F);
        set_rows(7'h7F);
        run_frame(6'd25, 0, 0);
        chk("s1_sum_const", 32'(res_sum), 49);
        chk("s1_bit_const", 32'(res_bit), 1);
        collect();

        // 2: no matches, thresh 1 then 0
        set_rows(7'h00);
        run_frame(6'd1, 0, 0);
        chk("s2_sum_const", 32'(res_sum), 0);
        collect();
        run_frame(6'd0, 0, 0);
        chk("s2_bit_thr0", 32'(res_bit), 1);
        collect();

        // 3: pc=3 per row -> 21; threshold at and above; mid-frame thresh change
        fill_w(7'h55);
        set_rows(7'h0F);
        run_frame(6'd21, 0, 0);
        chk("s3_sum_const", 32'(res_sum), 21);
        chk("s3_bit_eq", 32'(res_bit), 1);
        collect();
        run_frame(6'd22, 0, 1);
        chk("s3_bit_midthr", 32'(res_bit), 0);
        collect();

        // 4: backpressure with rows offered in DONE
        run_frame(6'd10, 0, 0);
        img_valid = 1'b1; img_row = 7'h0F;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_sum", 32'(res_sum), 21);
            chk("bp_bit", 32'(res_bit), 1);
            chk("bp_ready", 32'(img_ready), 0);
        end
        collect();
        chk("bp_next_ready", 32'(img_ready), 1);
        sb.push_back({6'd21, 1'b0});
        thresh = 6'd30;
        tick();
        chk("bp_first_row_taken", 32'(busy), 1);
        img_valid = 1'b0;
        for (int i = 1; i < 7; i++) send_row(7'h0F);
        collect();

        // 5: gaps, ignored ACCUM write, IDLE w_load gating, out-of-range address
        run_frame(6'd21, 1, 1);
        chk("s5_gap_sum", 32'(res_sum), 21);
        collect();
        w_load = 1'b1; img_valid = 1'b1; w_addr = 3'd7; w_data = 7'h00; #1;
        chk("wload_blocks_ready", 32'(img_ready), 0);
        tick();
        w_load = 1'b0; img_valid = 1'b0;
        chk("wload_no_start", 32'(busy), 0);
        run_frame(6'd21, 0, 0);
        chk("s5_addr7_sum", 32'(res_sum), 21);
        collect();

        // random kernel/rows through the model
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 7; i++) write_w(3'(i), 7'($urandom_range(0, 127)));
            for (int i = 0; i < 7; i++) frame_rows[i] = 7'($urandom_range(0, 127));
            run_frame(6'($urandom_range(0, 50)), 1, 0);
            collect();
        end

        // 6: reset mid-frame
        thresh = 6'd5;
        for (int i = 0; i < 3; i++) send_row(7'h3C);
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0; #1;
        chk("reset_gates_ready", 32'(img_ready), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) wm[i] = 7'h00;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(res_valid), 0);
        set_rows(7'h00);
        run_frame(6'd49, 0, 0);
        chk("s6_sum_const", 32'(res_sum), 49);
        collect();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
